// File: rtl/fp_divider.sv
// Multi-cycle IEEE-754 divider: restoring long division with round-to-nearest-even.
// Define FP_DIV_DENORM_EN to normalise denormal inputs and produce denormal results.
module fp_divider #(
    parameter int WIDTH          = 32,
    parameter int MANTISSA_WIDTH = 23,
    parameter int EXPONENT_WIDTH = 8,
    parameter int MAX_EXPONENT   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    output logic [WIDTH-1:0] output_z,
    output logic             complete,
    output logic             busy
);
    localparam int MW   = MANTISSA_WIDTH;
    localparam int EW   = EXPONENT_WIDTH;
    localparam int XW   = EW + 2;
    localparam int QW   = MW + 4;
    localparam int RW   = MW + 3;
    localparam int CW   = $clog2(QW + 1);
    localparam int BIAS = (MAX_EXPONENT + 1) / 2 - 1;

`ifdef FP_DIV_DENORM_EN
    localparam bit DENORM_EN = 1'b1;
`else
    localparam bit DENORM_EN = 1'b0;
`endif

    localparam logic signed [XW-1:0] ZERO_X     = '0;
    localparam logic signed [XW-1:0] ONE_X      = XW'(1);
    localparam logic signed [XW-1:0] BIAS_X     = XW'(BIAS);
    localparam logic signed [XW-1:0] EXP_MAX_X  = XW'(MAX_EXPONENT);
    localparam logic signed [XW-1:0] EXP_TOP_X  = XW'(MAX_EXPONENT - 1);
    localparam logic signed [XW-1:0] MIN_UF     = XW'(-1 - MW);

    typedef enum logic [3:0] {
        IDLE, UNPACK, SPECIAL, NORM_A, NORM_B, DIV_INIT,
        DIVIDE, NORMALISE, DENORM, ROUND, PACK, PUT_Z
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]        a, b, z_out;
    logic                    a_s, b_s, z_s;
    logic signed [XW-1:0]    a_e, b_e, z_e;
    logic [MW:0]             a_m, b_m, z_m;
    logic [RW-1:0]           rem;
    logic [QW-1:0]           q;
    logic [CW-1:0]           cnt;
    logic                    guard, round_bit, sticky;

    logic                    a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, special_case;
    logic [RW-1:0]           b_ext, rem_diff;
    logic                    rem_ge;

    // Operand classification, valid from SPECIAL onward
    always_comb begin
        a_nan  = (a_e == EXP_MAX_X) && (a_m != '0);
        b_nan  = (b_e == EXP_MAX_X) && (b_m != '0);
        a_inf  = (a_e == EXP_MAX_X) && (a_m == '0);
        b_inf  = (b_e == EXP_MAX_X) && (b_m == '0);
        a_zero = (a_e == ZERO_X) && (!DENORM_EN || (a_m == '0));
        b_zero = (b_e == ZERO_X) && (!DENORM_EN || (b_m == '0));
        special_case = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
        b_ext    = {2'b00, b_m};
        rem_ge   = (rem >= b_ext);
        rem_diff = rem - b_ext;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (en) state_nxt = UNPACK;
            UNPACK:    state_nxt = SPECIAL;
            SPECIAL:   state_nxt = special_case ? PUT_Z : NORM_A;
            NORM_A:    if (!DENORM_EN || a_m[MW]) state_nxt = NORM_B;
            NORM_B:    if (!DENORM_EN || b_m[MW]) state_nxt = DIV_INIT;
            DIV_INIT:  state_nxt = DIVIDE;
            DIVIDE:    if (cnt == CW'(1)) state_nxt = NORMALISE;
            NORMALISE: state_nxt = DENORM;
            DENORM:    if (!(DENORM_EN && (z_e < ONE_X) && (z_e > MIN_UF))) state_nxt = ROUND;
            ROUND:     state_nxt = PACK;
            PACK:      state_nxt = PUT_Z;
            PUT_Z:     state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a         <= '0;
            b         <= '0;
            z_out     <= '0;
            a_s       <= 1'b0;
            b_s       <= 1'b0;
            z_s       <= 1'b0;
            a_e       <= '0;
            b_e       <= '0;
            z_e       <= '0;
            a_m       <= '0;
            b_m       <= '0;
            z_m       <= '0;
            rem       <= '0;
            q         <= '0;
            cnt       <= '0;
            guard     <= 1'b0;
            round_bit <= 1'b0;
            sticky    <= 1'b0;
            output_z  <= '0;
            complete  <= 1'b0;
        end else begin
            complete <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        a <= input_a;
                        b <= input_b;
                    end
                end
                UNPACK: begin
                    a_s <= a[WIDTH-1];
                    b_s <= b[WIDTH-1];
                    a_e <= {2'b00, a[WIDTH-2:MW]};
                    b_e <= {2'b00, b[WIDTH-2:MW]};
                    a_m <= {1'b0, a[MW-1:0]};
                    b_m <= {1'b0, b[MW-1:0]};
                end
                SPECIAL: begin
                    z_s <= a_s ^ b_s;
                    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
                        z_out <= {1'b1, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
                    end else if (a_inf || b_zero) begin
                        z_out <= {a_s ^ b_s, {EW{1'b1}}, {MW{1'b0}}};
                    end else if (a_zero || b_inf) begin
                        z_out <= {a_s ^ b_s, {EW{1'b0}}, {MW{1'b0}}};
                    end else begin
                        // Zero exponent field here can only be a denormal
                        if (a_e == ZERO_X) a_e <= ONE_X;
                        else               a_m[MW] <= 1'b1;
                        if (b_e == ZERO_X) b_e <= ONE_X;
                        else               b_m[MW] <= 1'b1;
                    end
                end
                NORM_A: begin
                    if (DENORM_EN && !a_m[MW]) begin
                        a_m <= a_m << 1;
                        a_e <= a_e - ONE_X;
                    end
                end
                NORM_B: begin
                    if (DENORM_EN && !b_m[MW]) begin
                        b_m <= b_m << 1;
                        b_e <= b_e - ONE_X;
                    end
                end
                DIV_INIT: begin
                    z_e <= a_e - b_e + BIAS_X;
                    rem <= {2'b00, a_m};
                    q   <= '0;
                    cnt <= CW'(QW);
                end
                DIVIDE: begin
                    q   <= {q[QW-2:0], rem_ge};
                    rem <= (rem_ge ? rem_diff : rem) << 1;
                    cnt <= cnt - CW'(1);
                end
                NORMALISE: begin
                    if (q[QW-1]) begin
                        z_m       <= q[QW-1:3];
                        guard     <= q[2];
                        round_bit <= q[1];
                        sticky    <= q[0] | (rem != '0);
                    end else begin
                        z_m       <= q[QW-2:2];
                        guard     <= q[1];
                        round_bit <= q[0];
                        sticky    <= (rem != '0);
                        z_e       <= z_e - ONE_X;
                    end
                end
                DENORM: begin
                    if (z_e < ONE_X) begin
                        if (!DENORM_EN || (z_e <= MIN_UF)) begin
                            z_m       <= '0;
                            z_e       <= ZERO_X;
                            guard     <= 1'b0;
                            round_bit <= 1'b0;
                            sticky    <= 1'b0;
                        end else begin
                            z_m       <= z_m >> 1;
                            z_e       <= z_e + ONE_X;
                            guard     <= z_m[0];
                            round_bit <= guard;
                            sticky    <= sticky | round_bit;
                        end
                    end
                end
                ROUND: begin
                    if (guard && (round_bit || sticky || z_m[0])) begin
                        if (z_m == '1) begin
                            z_m <= {1'b1, {MW{1'b0}}};
                            z_e <= z_e + ONE_X;
                        end else begin
                            z_m <= z_m + (MW+1)'(1);
                        end
                    end
                end
                PACK: begin
                    if (z_e > EXP_TOP_X) begin
                        z_out <= {z_s, {EW{1'b1}}, {MW{1'b0}}};
                    end else if ((z_e == ONE_X) && !z_m[MW]) begin
                        z_out <= {z_s, {EW{1'b0}}, z_m[MW-1:0]};
                    end else begin
                        z_out <= {z_s, z_e[EW-1:0], z_m[MW-1:0]};
                    end
                end
                PUT_Z: begin
                    output_z <= z_out;
                    complete <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/fp_divider.md
# fp_divider

Multi-cycle IEEE-754 floating-point divider (single precision by default) computing output_z = input_a / input_b. It uses restoring long division with round-to-nearest-even. It is the inverse-operation companion to the FPU's multi-cycle multiplier and shares its operand format, special-value encodings and `complete` reporting. It sits beside the multiplier in the FPU datapath and is driven by the same sequencer.

## Interface
- WIDTH, 32: total word width (64 for double).
- MANTISSA_WIDTH, 23: stored fraction bits (52 for double).
- EXPONENT_WIDTH, 8: exponent bits (11 for double).
- MAX_EXPONENT, 255: all-ones exponent (2047 for double); bias = (MAX_EXPONENT+1)/2-1.
- clk  input  1  sole clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- en  input  1  start strobe; sampled only in IDLE.
- input_a  input  WIDTH  dividend; captured on the accepting edge.
- input_b  input  WIDTH  divisor; captured on the accepting edge.
- output_z  output  WIDTH  quotient; holds its value until the next result or reset.
- complete  output  1  one-cycle pulse when output_z updates.
- busy  output  1  high from the accepting edge until the edge that raises complete.

## Operation
- Reset (rst=0, asynchronous): state=IDLE, output_z=0, complete=0, busy=0, all internal registers cleared. Reset mid-division abandons the operation; no complete is issued.
- IDLE: when en=1, capture a and b, set busy, go to UNPACK. en while busy is ignored; en=0 never aborts an operation.
- UNPACK: split each operand into sign, exponent (EXPONENT_WIDTH+2 bits, signed) and mantissa (MANTISSA_WIDTH+1 bits).
- SPECIAL: evaluated in this priority order, each going to PUT_Z:
  - Either operand NaN, inf/inf, or 0/0: result 0xFFC00000 (sign 1, max exponent, fraction MSB 1).
  - a inf, or b zero: result ±inf.
  - a zero, or b inf: result ±0.
  - Result sign is always sa^sb, except for NaN.
  - Otherwise: exponent 0 → exponent 1 (denormal); else set the hidden bit. Go to NORM_A.
- NORM_A / NORM_B: while the hidden bit is 0, shift the mantissa left 1 and decrement the exponent, one bit per cycle. When the hidden bit is 1, advance.
- DIV_INIT:
  - z_e = a_e - b_e + bias.
  - remainder = a_m, zero-extended to MANTISSA_WIDTH+3 bits.
  - Clear quotient q (MANTISSA_WIDTH+4 bits); load the iteration counter with MANTISSA_WIDTH+4.
- DIVIDE: one quotient bit per cycle, MSB first.
  - If remainder ≥ b_m: q bit = 1 and remainder -= b_m.
  - Then shift the remainder left 1.
  - Exit when the counter reaches 0.
- NORMALISE:
  - If q MSB = 1: mantissa = q[top:3], guard = q[2], round = q[1], sticky = q[0] | (remainder≠0).
  - Else: mantissa = q[top-1:2], guard = q[1], round = q[0], sticky = (remainder≠0), and z_e -= 1.
- DENORM:
  - While z_e < 1 and z_e > -1-MANTISSA_WIDTH: shift the mantissa right 1 and increment z_e. Guard, round and sticky shift down; sticky ORs in the old round bit.
  - If z_e ≤ -1-MANTISSA_WIDTH: mantissa = 0, z_e = 0.
- ROUND: if guard & (round | sticky | mantissa[0]), increment the mantissa. If the mantissa was all ones, the mantissa becomes 1<<MANTISSA_WIDTH and z_e += 1.
- PACK:
  - z_e > MAX_EXPONENT-1: ±inf.
  - z_e = 1 and hidden bit 0: denormal encoding (exponent field 0).
  - Otherwise: normal encoding.
- PUT_Z: load output_z, pulse complete, clear busy, return to IDLE.

## Timing
- Edge 0 is the edge that samples en=1 in IDLE.
- Special-case results: complete is high in the cycle after edge 3.
- Normal operands, result needs no denormal shift: complete follows edge 37. This is 5 setup cycles + MANTISSA_WIDTH+4 divide cycles + 5 tail cycles.
- Each leading-zero bit of a denormal input adds 1 cycle; each denormalising right shift of the result adds 1 cycle.
- complete is high for exactly one cycle. Back-to-back operation: en may be asserted in the cycle complete is high; it is accepted on the next edge (IDLE).

## Configuration
- FP_DIV_DENORM_EN defined: denormal inputs are normalised and denormal results produced, as above.
- FP_DIV_DENORM_EN undefined:
  - Denormal inputs are treated as ±0 in SPECIAL.
  - NORM_A/NORM_B are bypassed in 1 cycle each.
  - Any result with z_e < 1 after NORMALISE is flushed to ±0.
  - Normal-operand latency is unchanged.

## Test plan
- 0x40C00000 / 0x40000000 (6.0/2.0) → output_z=0x40400000; complete exactly after edge 37; busy high edges 0–37.
- 0x3F800000 / 0x40400000 (1.0/3.0) → 0x3EAAAAAB (round-to-nearest-even increments).
- Special cases, each with complete after edge 3:
  - 0x3F800000 / 0x00000000 → 0x7F800000.
  - 0xBF800000 / 0x00000000 → 0xFF800000.
  - 0x00000000 / 0x00000000 → 0xFFC00000.
  - 0x7FC00001 / 0x3F800000 → 0xFFC00000.
- Overflow: 0x7F000000 / 0x3E800000 → 0x7F800000.
- Underflow: 0x00800000 / 0x40000000 → 0x00400000 with FP_DIV_DENORM_EN, 0x00000000 without.
- Reset during DIVIDE: drive rst low at edge 15 → output_z=0, complete=0, busy=0 immediately, with no later complete. After release, en with 6.0/2.0 → 0x40400000; en pulses while busy are ignored.
